// File: rtl/calc_seq.sv
// Sequential calculator: single-cycle add/sub/mul/not, and a multi-cycle restoring
// divider for div/mod. Each result is held in DONE until the consumer accepts it.
module calc_seq #(
    parameter  int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIVIDE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [RES_W-1:0]   out_q, out_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;

    logic [RES_W-1:0]   exec_res;
    logic               exec_err;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               is_divmod;

    // Single-cycle results; div/mod only reach EXEC when b is zero, so they
    // fall into the error branch together with the illegal opcodes.
    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        case (op_q)
            OP_ADD:  exec_res = RES_W'(a_q) + RES_W'(b_q);
            OP_SUB:  exec_res = RES_W'(a_q) - RES_W'(b_q);
            OP_MUL:  exec_res = RES_W'(a_q) * RES_W'(b_q);
            OP_NOT:  exec_res = {{WIDTH{1'b0}}, ~a_q};
            default: exec_err = 1'b1;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits. The quotient register starts out
    // holding the dividend and fills with quotient bits from the bottom.
    always_comb begin
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        rem_nxt   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], div_ge};
    end

    assign is_divmod = (oper == OP_DIV) || (oper == OP_MOD);

    // NOTE: every variable assigned here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        out_d   = out_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = oper;
                    if (is_divmod && (b != '0)) begin
                        state_d = S_DIVIDE;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                out_d   = exec_res;
                err_d   = exec_err;
                state_d = S_DONE;
            end
            S_DIVIDE: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    out_d   = (op_q == OP_DIV) ? RES_W'(quo_nxt) : RES_W'(rem_nxt);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples its
    // next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign err       = err_q;

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RES_W, fixed at 2*WIDTH, giving the result width in bits (derived, not overridable).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and opcode are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a new operation.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-009 The block SHALL have port oper, input, 3 bits: opcode, encoded 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 not; 110 and 111 are illegal.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port out, output, RES_W bits: result.
REQ-013 The block SHALL have port err, output, 1 bit: error flag, qualified by out_valid.

Function
REQ-014 An operation SHALL be accepted only on a rising edge where in_valid and in_ready are both 1; a, b and oper SHALL be captured at that edge.
REQ-015 The FSM SHALL have states IDLE, EXEC, DIVIDE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 On accept: div or mod with b!=0 SHALL go IDLE->DIVIDE; every other opcode SHALL go IDLE->EXEC.
REQ-017 EXEC SHALL last exactly 1 cycle and then go to DONE, so out_valid rises on the second edge after accept.
REQ-018 DIVIDE SHALL run a restoring shift-subtract division for exactly WIDTH cycles and then go to DONE, so out_valid rises WIDTH+1 edges after accept.
REQ-019 DONE SHALL hold out_valid=1 and keep out and err stable until an edge with out_ready=1, then go to IDLE; there SHALL be no bypass from DONE directly to accept.
REQ-020 Add SHALL produce out = a+b, zero-extended, with no overflow possible.
REQ-021 Sub SHALL produce out = (a-b) mod 2^RES_W, i.e. two's-complement wrap in RES_W bits.
REQ-022 Mul SHALL produce out = a*b, unsigned, using the full RES_W bits.
REQ-023 Div SHALL produce out = floor(a/b), zero-extended.
REQ-024 Mod SHALL produce out = a mod b, zero-extended.
REQ-025 Not SHALL produce out = {WIDTH zeros, ~a}, ignoring b.
REQ-026 Div or mod with b=0 SHALL produce err=1 and out=0 through EXEC (latency 2), without entering DIVIDE.
REQ-027 Opcodes 110 and 111 SHALL produce err=1 and out=0 through EXEC.
REQ-028 err SHALL be 0 for every legal opcode whose result is valid.
REQ-029 in_valid asserted outside IDLE SHALL be ignored, with no capture and no side effects.
REQ-030 Input changes after accept SHALL NOT affect an in-flight result.

Reset
REQ-031 Assertion of rst_n=0 SHALL immediately, with no clock required, force state=IDLE, in_ready=1, out_valid=0, out=0, err=0, and clear all datapath registers.
REQ-032 A reset asserted mid-DIVIDE or in DONE SHALL abort the operation; no result SHALL be emitted after release.
REQ-033 After rst_n deasserts, the first accept SHALL be possible on the next rising edge.

Verification (WIDTH=4)
REQ-034 Add: a=15, b=15, oper=000 accepted -> out=0x1E, err=0, out_valid on the 2nd edge after accept.
REQ-035 Sub, mul, not: a=3, b=5, sub -> out=0xFE; a=15, b=15, mul -> out=0xE1; a=0x5, not -> out=0x0A.
REQ-036 Div and mod: a=13, b=4, div -> out=0x03 with out_valid 5 edges after accept; the same operands with mod -> out=0x01.
REQ-037 Errors: a=9, b=0, div -> err=1, out=0 after 2 edges; oper=111 -> err=1, out=0.
REQ-038 Backpressure: out_ready=0 for 10 cycles after out_valid -> out, err and out_valid hold, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-039 Reset mid-divide: rst_n pulsed low at DIVIDE cycle 2 -> out_valid=0 and in_ready=1 immediately, and the next op (3+4) returns 0x07.
